// File: rtl/eth_led_pkg.sv
// Shared types and default timing constants for the Ethernet PHY LED driver.
package eth_led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    OFF  = 2'b10
  } led_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int BLINK_HALF_DEF      = 8;

endpackage

// File: rtl/eth_led_debounce.sv
// Debounces a slow status input: dout flips only after DEBOUNCE_CYCLES
// consecutive samples disagree with it.
module eth_led_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (din != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = ~stable_q;
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/eth_phy_led_driver.sv
// Link / speed / activity LED driver for an Ethernet PHY.
// Define ETH_LED_ACTIVE_LOW_EN for active-low LED outputs.
module eth_phy_led_driver
  import eth_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BLINK_HALF      = BLINK_HALF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic link_up,
  input  logic speed_100,
  input  logic rx_act,
  input  logic tx_act,
  output logic led_0,
  output logic led_1,
  output logic led_2
);

`ifdef ETH_LED_ACTIVE_LOW_EN
  localparam logic LED_INV = 1'b1;
`else
  localparam logic LED_INV = 1'b0;
`endif

  localparam int PW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_HALF - 1);

  logic          link_stable;
  logic          act;
  logic          phase_last;
  led_state_e    state_q;
  logic [PW-1:0] phase_q;
  logic          pend_q;
  logic          led_0_q, led_1_q, led_2_q;

  eth_led_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_link_db (
    .clk (clk),
    .rst (rst),
    .din (link_up),
    .dout(link_stable)
  );

  assign act        = rx_act | tx_act;
  assign phase_last = (phase_q == PHASE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_0_q <= LED_INV;
      led_1_q <= LED_INV;
    end else begin
      led_0_q <= link_stable ^ LED_INV;
      led_1_q <= (link_stable & speed_100) ^ LED_INV;
    end
  end

  // Loss of the debounced link wins over everything, including fresh activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      pend_q  <= 1'b0;
      led_2_q <= LED_INV;
    end else if (!link_stable) begin
      state_q <= IDLE;
      phase_q <= '0;
      pend_q  <= 1'b0;
      led_2_q <= LED_INV;
    end else begin
      case (state_q)
        IDLE: begin
          if (act) begin
            state_q <= ON;
            phase_q <= '0;
            led_2_q <= ~LED_INV;
          end
        end
        ON: begin
          if (act) pend_q <= 1'b1;
          if (phase_last) begin
            state_q <= OFF;
            phase_q <= '0;
            led_2_q <= LED_INV;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        OFF: begin
          if (phase_last) begin
            phase_q <= '0;
            pend_q  <= 1'b0;
            // Activity on the expiry edge itself still earns another blink.
            if (pend_q | act) begin
              state_q <= ON;
              led_2_q <= ~LED_INV;
            end else begin
              state_q <= IDLE;
              led_2_q <= LED_INV;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
            if (act) pend_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          phase_q <= '0;
          pend_q  <= 1'b0;
          led_2_q <= LED_INV;
        end
      endcase
    end
  end

  assign led_0 = led_0_q;
  assign led_1 = led_1_q;
  assign led_2 = led_2_q;

endmodule

// File: tb/tb_eth_phy_led_driver.sv
// Scoreboard bench for eth_phy_led_driver (defaults 16/8); honours ETH_LED_ACTIVE_LOW_EN.
module tb_eth_phy_led_driver;

`ifdef ETH_LED_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic link_up = 1'b0, speed_100 = 1'b0, rx_act = 1'b0, tx_act = 1'b0;
  logic led_0, led_1, led_2;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q[$];
  string      tag_q[$];

  eth_phy_led_driver dut (
    .clk(clk), .rst(rst), .link_up(link_up), .speed_100(speed_100),
    .rx_act(rx_act), .tx_act(tx_act),
    .led_0(led_0), .led_1(led_1), .led_2(led_2)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Monitor: LEDs are registered, so every clock presents a new output word.
  initial begin
    logic [2:0] e;
    string      t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if ({led_0, led_1, led_2} !== (e ^ {3{INV}})) begin
          errors++;
          $display("FAIL %s: leds(0,1,2) got %b expected %b", t,
                   {led_0, led_1, led_2}, e ^ {3{INV}});
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the LED word expected after the next edge
  // (expected values written active-high; the monitor applies the build polarity).
  task automatic cyc(input logic r, l, s, rx, tx, input logic [2:0] e, input string t);
    @(negedge clk);
    rst = r; link_up = l; speed_100 = s; rx_act = rx; tx_act = tx;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic cycn(input int n, input logic r, l, s, input logic [2:0] e, input string t);
    for (int i = 0; i < n; i++) cyc(r, l, s, 1'b0, 1'b0, e, t);
  endtask

  initial begin
    // reset and idle, activity ignored while link down
    cycn(3, 1'b1, 1'b0, 1'b0, 3'b000, "reset");
    cycn(3, 1'b0, 1'b0, 1'b1, 3'b000, "post_reset");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, "act_link_down");
    cycn(3, 1'b0, 1'b0, 1'b1, 3'b000, "act_link_down_after");

    // 15-cycle glitch must not flip the link
    cycn(15, 1'b0, 1'b1, 1'b1, 3'b000, "glitch15");
    cycn(10, 1'b0, 1'b0, 1'b1, 3'b000, "glitch15_after");

    // clean rise: led_0/led_1 rise on the 17th sampled edge (16 cycles after the first)
    cycn(16, 1'b0, 1'b1, 1'b1, 3'b000, "link_rise_wait");
    cycn(3, 1'b0, 1'b1, 1'b1, 3'b110, "link_rise");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, "speed_10");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b110, "speed_100_back");

    // single rx pulse: 8 on, 8 off, idle
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, "blink1_start");
    cycn(7, 1'b0, 1'b1, 1'b1, 3'b111, "blink1_on");
    cycn(8, 1'b0, 1'b1, 1'b1, 3'b110, "blink1_off");
    cycn(4, 1'b0, 1'b1, 1'b1, 3'b110, "blink1_idle");

    // rx at ON cycle 3, tx at OFF cycle 5 -> two consecutive blinks
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, "blink2_start");
    cycn(2, 1'b0, 1'b1, 1'b1, 3'b111, "blink2_on_a");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, "blink2_on_rx");
    cycn(4, 1'b0, 1'b1, 1'b1, 3'b111, "blink2_on_b");
    cycn(5, 1'b0, 1'b1, 1'b1, 3'b110, "blink2_off_a");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b110, "blink2_off_tx");
    cycn(2, 1'b0, 1'b1, 1'b1, 3'b110, "blink2_off_b");
    cycn(8, 1'b0, 1'b1, 1'b1, 3'b111, "blink2_second_on");
    cycn(8, 1'b0, 1'b1, 1'b1, 3'b110, "blink2_second_off");
    cycn(4, 1'b0, 1'b1, 1'b1, 3'b110, "blink2_idle");

    // rx+tx together plus two more pulses in ON collapse into one extra blink
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b111, "collapse_start");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, "collapse_on");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, "collapse_rx");
    cycn(2, 1'b0, 1'b1, 1'b1, 3'b111, "collapse_on");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b111, "collapse_tx");
    cycn(2, 1'b0, 1'b1, 1'b1, 3'b111, "collapse_on");
    cycn(8, 1'b0, 1'b1, 1'b1, 3'b110, "collapse_off");
    cycn(8, 1'b0, 1'b1, 1'b1, 3'b111, "collapse_second_on");
    cycn(8, 1'b0, 1'b1, 1'b1, 3'b110, "collapse_second_off");
    cycn(4, 1'b0, 1'b1, 1'b1, 3'b110, "collapse_idle");

    // link drop completes mid-ON: all LEDs fall together
    cycn(11, 1'b0, 1'b0, 1'b1, 3'b110, "drop_debounce");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111, "drop_blink_start");
    cycn(4, 1'b0, 1'b0, 1'b1, 3'b111, "drop_blink_on");
    cycn(3, 1'b0, 1'b0, 1'b1, 3'b000, "drop_forced_idle");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, "drop_act_ignored");
    cycn(3, 1'b0, 1'b0, 1'b1, 3'b000, "drop_after");

    // relink, start a blink, then async reset mid-ON
    cycn(16, 1'b0, 1'b1, 1'b1, 3'b000, "relink_wait");
    cycn(2, 1'b0, 1'b1, 1'b1, 3'b110, "relink");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, "rst_blink_start");
    cycn(2, 1'b0, 1'b1, 1'b1, 3'b111, "rst_blink_on");
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({led_0, led_1, led_2} !== {3{INV}}) begin
      errors++;
      $display("FAIL async_reset_immediate: leds(0,1,2) got %b expected %b",
               {led_0, led_1, led_2}, {3{INV}});
    end
    cycn(3, 1'b1, 1'b1, 1'b1, 3'b000, "reset_mid_on");
    // progress discarded: a full fresh debounce count is needed
    cycn(16, 1'b0, 1'b1, 1'b1, 3'b000, "post_reset_wait");
    cycn(3, 1'b0, 1'b1, 1'b1, 3'b110, "post_reset_link");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending entries got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_phy_led_driver.md
ETH_PHY_LED_DRIVER -- requirements
Module: eth_phy_led_driver

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive cycles link_up must differ from the debounced link state before that state flips.
REQ-002 Parameter BLINK_HALF, default 8: cycles per activity blink half-period (ON phase and OFF phase each).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 link_up  input  1  raw link-established status from the MAC/PCS.
REQ-006 speed_100  input  1  1 = link negotiated at 100BASE-T.
REQ-007 rx_act  input  1  single-cycle receive-frame pulse.
REQ-008 tx_act  input  1  single-cycle transmit-frame pulse.
REQ-009 led_0  output  1  link established, registered.
REQ-010 led_1  output  1  100BASE-T link, registered.
REQ-011 led_2  output  1  RX/TX activity blink, registered.

Function
REQ-012 Debounce: a counter shall count consecutive cycles with link_up != link_stable, cleared to 0 on any cycle where they match.
REQ-013 link_stable shall toggle on the edge where the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present; the counter clears on that edge.
REQ-014 led_0 shall equal link_stable, registered, so it changes exactly DEBOUNCE_CYCLES cycles after a clean link_up transition.
REQ-015 led_1 shall be registered link_stable AND speed_100; speed_100 is not debounced.
REQ-016 Activity FSM states: IDLE (led_2=0), ON (led_2=1), OFF (led_2=0); phase counter width clog2(BLINK_HALF).
REQ-017 IDLE -> ON when (rx_act OR tx_act) is sampled with link_stable=1; led_2 is high from the next cycle.
REQ-018 ON lasts exactly BLINK_HALF cycles, then OFF; OFF lasts exactly BLINK_HALF cycles.
REQ-019 A pending flag shall set on any rx_act/tx_act sampled in ON or OFF; on OFF expiry, pending=1 -> ON (pending cleared), else -> IDLE.
REQ-020 rx_act and tx_act in the same cycle count as one event; multiple events within one blink collapse into one pending blink.
REQ-021 Activity with link_stable=0 shall be ignored.
REQ-022 link_stable falling shall force IDLE on the same edge and clear pending and the phase counter, overriding any simultaneous activity.

Reset
REQ-023 rst asserted shall immediately set led_0=0, led_1=0, led_2=0, link_stable=0, debounce counter=0, FSM=IDLE, pending=0.
REQ-024 Reset mid-blink or mid-debounce shall discard all progress; after deassertion a fresh DEBOUNCE_CYCLES count is required.

Configuration
REQ-025 Macro ETH_LED_ACTIVE_LOW_EN defined: all three LED outputs are inverted at the output register (reset value 1, lit = 0).
REQ-026 Macro undefined: outputs active-high as in REQ-009..REQ-023; internal logic is identical in both builds.

Structure
REQ-027 Package eth_led_pkg shall hold the FSM state typedef (IDLE=2'b00, ON=2'b01, OFF=2'b10) and the default DEBOUNCE_CYCLES/BLINK_HALF constants.
REQ-028 The debounce logic shall be a sub-module eth_led_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, din, dout), instantiated once for link_up.
REQ-029 Unreachable FSM encoding 2'b11 shall recover to IDLE on the next edge.

Verification (defaults 16/8)
REQ-030 link_up 0->1 held -> led_0 rises exactly 16 cycles later; with speed_100=1, led_1 rises on the same cycle.
REQ-031 link_up glitch high for 15 cycles -> led_0 stays 0, counter returns to 0.
REQ-032 Link up, one rx_act pulse -> led_2 high 8 cycles, low 8 cycles, then IDLE; total one blink.
REQ-033 Link up, rx_act at ON cycle 3 plus tx_act at OFF cycle 5 -> exactly two consecutive blinks (32 cycles), then IDLE.
REQ-034 Link drops (16-cycle debounce completes) during ON -> led_2 low and FSM IDLE on that same edge; led_0 and led_1 low.
REQ-035 rst asserted mid-ON -> all LEDs 0 immediately; build with ETH_LED_ACTIVE_LOW_EN -> all LEDs 1 in reset and inverted in REQ-030..REQ-034.
